// File: rtl/grid_render_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grid_render_pkg
//  Description : Shared definitions for the grid cell renderer: cell-state
//                codes, pixel colours, FSM state encoding and the
//                cell-state to colour mapping.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package grid_render_pkg;

  // Cell-state codes held in each 2-bit board slot
  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_X     = 2'd1;
  localparam logic [1:0] CELL_O     = 2'd2;
  localparam logic [1:0] CELL_RSVD  = 2'd3;

  // Fill colours
  localparam logic [2:0] COL_EMPTY = 3'b000;
  localparam logic [2:0] COL_X     = 3'b100;
  localparam logic [2:0] COL_O     = 3'b001;

  // Renderer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DRAW = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Reserved code is drawn as an empty cell
  function automatic logic [2:0] cell_colour(input logic [1:0] state);
    case (state)
      CELL_X:  return COL_X;
      CELL_O:  return COL_O;
      default: return COL_EMPTY;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cell_raster_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cell_raster_counter
//  Description : Walks a CELL_W x CELL_W square in raster order (cx fastest).
//                Cleared to (0,0) on i_clear, steps once per i_advance.
//  Ports       : clk        in  clock
//                reset      in  asynchronous active-high reset
//                i_clear    in  return to (0,0)
//                i_advance  in  step to the next pixel
//                o_row_end  out current pixel is at cx = CELL_W-1
//                o_last     out current pixel is the last of the square
//  Revision    : 1.0  initial release
// ============================================================================
module cell_raster_counter #(
  parameter int CELL_W = 26,
  parameter int CW     = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_advance,
  output logic o_row_end,
  output logic o_last
);

  localparam logic [CW-1:0] C_MAX = CW'(CELL_W - 1);

  logic [CW-1:0] r_cx;
  logic [CW-1:0] r_cy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_clear) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_advance) begin
      if (r_cx == C_MAX) begin
        r_cx <= '0;
        r_cy <= (r_cy == C_MAX) ? '0 : r_cy + CW'(1);
      end else begin
        r_cx <= r_cx + CW'(1);
      end
    end
  end

  assign o_row_end = (r_cx == C_MAX);
  assign o_last    = o_row_end && (r_cy == C_MAX);

endmodule
`default_nettype wire

// File: rtl/grid_cell_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : grid_cell_renderer
//  Description : Scans a GRID_N x GRID_N board of 2-bit cells and streams one
//                solid CELL_W x CELL_W square per cell as plotted pixels.
//                Full redraw or dirty-only redraw, with plot/plot_ready
//                handshake toward the VGA adapter.
//  Ports       : clk            in  clock
//                reset          in  asynchronous active-high reset
//                i_start        in  begin a pass (honoured only when idle)
//                i_full_redraw  in  sampled with start: 1 all cells, 0 dirty
//                i_cell_state   in  board, cell k at bits [2k+1:2k]
//                i_plot_ready   in  VGA side accepts current pixel
//                o_plot         out pixel outputs valid
//                o_x_out        out pixel x
//                o_y_out        out pixel y
//                o_colour_out   out pixel colour
//                o_busy         out pass in progress
//                o_done         out one-cycle end-of-pass pulse
//  Revision    : 1.0  initial release
// ============================================================================
module grid_cell_renderer
  import grid_render_pkg::*;
#(
  parameter int GRID_N   = 3,
  parameter int CELL_W   = 26,
  parameter int GAP      = 1,
  parameter int X0       = 0,
  parameter int Y0       = 0,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
  input  logic                       i_full_redraw,
  input  logic [2*GRID_N*GRID_N-1:0] i_cell_state,
  input  logic                       i_plot_ready,
  output logic                       o_plot,
  output logic [X_W-1:0]             o_x_out,
  output logic [Y_W-1:0]             o_y_out,
  output logic [COLOUR_W-1:0]        o_colour_out,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int NCELL = GRID_N * GRID_N;
  localparam int PITCH = CELL_W + GAP;
  localparam int KW    = (NCELL  > 1) ? $clog2(NCELL)  : 1;
  localparam int RW    = (GRID_N > 1) ? $clog2(GRID_N) : 1;
  localparam int CW    = (CELL_W > 1) ? $clog2(CELL_W) : 1;

  // The last cell must still fit inside the coordinate range
  if (X0 + GRID_N * PITCH > (1 << X_W)) begin : g_x_range_chk
    $error("grid_cell_renderer: board exceeds X_W coordinate range");
  end
  if (Y0 + GRID_N * PITCH > (1 << Y_W)) begin : g_y_range_chk
    $error("grid_cell_renderer: board exceeds Y_W coordinate range");
  end

  state_t r_state, w_next_state;

  logic [1:0]       r_snap  [NCELL];
  logic [1:0]       r_drawn [NCELL];
  logic [NCELL-1:0] r_drawn_valid;
  logic             r_full;

  // Cell index kept alongside its row/column so no divider is needed
  logic [KW-1:0]    r_k;
  logic [RW-1:0]    r_col;
  logic [RW-1:0]    r_row;

  logic                r_plot;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_busy;
  logic                r_done;

  logic           w_draw_cell;
  logic           w_last_cell;
  logic           w_accept;
  logic           w_row_end;
  logic           w_last_pix;
  logic [X_W-1:0] w_base_x;
  logic [Y_W-1:0] w_base_y;

  assign w_draw_cell = r_full || !r_drawn_valid[r_k] || (r_snap[r_k] != r_drawn[r_k]);
  assign w_last_cell = (r_k == KW'(NCELL - 1));
  assign w_accept    = r_plot && i_plot_ready;
  assign w_base_x    = X_W'(X0 + int'(r_col) * PITCH);
  assign w_base_y    = Y_W'(Y0 + int'(r_row) * PITCH);

  cell_raster_counter #(
    .CELL_W (CELL_W),
    .CW     (CW)
  ) u_raster (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (r_state == ST_SCAN),
    .i_advance ((r_state == ST_DRAW) && w_accept),
    .o_row_end (w_row_end),
    .o_last    (w_last_pix)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next_state = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_draw_cell)      w_next_state = ST_DRAW;
        else if (w_last_cell) w_next_state = ST_FIN;
      end
      ST_DRAW: begin
        if (w_accept && w_last_pix) w_next_state = w_last_cell ? ST_FIN : ST_SCAN;
      end
      ST_FIN: begin
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCELL; i++) begin
        r_snap[i]  <= CELL_EMPTY;
        r_drawn[i] <= CELL_EMPTY;
      end
      r_drawn_valid <= '0;
      r_full        <= 1'b0;
      r_k           <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_plot        <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_colour      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            for (int i = 0; i < NCELL; i++) begin
              r_snap[i] <= i_cell_state[2*i +: 2];
            end
            r_full <= i_full_redraw;
            r_busy <= 1'b1;
            r_k    <= '0;
            r_col  <= '0;
            r_row  <= '0;
          end
        end
        ST_SCAN: begin
          if (w_draw_cell) begin
            r_plot   <= 1'b1;
            r_x      <= w_base_x;
            r_y      <= w_base_y;
            r_colour <= COLOUR_W'(cell_colour(r_snap[r_k]));
          end else begin
            r_k <= r_k + KW'(1);
            if (r_col == RW'(GRID_N - 1)) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + RW'(1);
            end
          end
        end
        ST_DRAW: begin
          if (w_accept) begin
            if (w_last_pix) begin
              r_drawn[r_k]       <= r_snap[r_k];
              r_drawn_valid[r_k] <= 1'b1;
              r_plot             <= 1'b0;
              r_k                <= r_k + KW'(1);
              if (r_col == RW'(GRID_N - 1)) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
              end else begin
                r_col <= r_col + RW'(1);
              end
            end else if (w_row_end) begin
              r_x <= w_base_x;
              r_y <= r_y + Y_W'(1);
            end else begin
              r_x <= r_x + X_W'(1);
            end
          end
        end
        ST_FIN: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_plot       = r_plot;
  assign o_x_out      = r_x;
  assign o_y_out      = r_y;
  assign o_colour_out = r_colour;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_grid_cell_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grid_cell_renderer
//  Description : Directed self-checking bench for grid_cell_renderer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_grid_cell_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        full_redraw;
  logic [17:0] cell_state;
  logic        plot_ready;
  logic        o_plot;
  logic [7:0]  o_x;
  logic [6:0]  o_y;
  logic [2:0]  o_col;
  logic        o_busy;
  logic        o_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  grid_cell_renderer dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (start),
    .i_full_redraw (full_redraw),
    .i_cell_state  (cell_state),
    .i_plot_ready  (plot_ready),
    .o_plot        (o_plot),
    .o_x_out       (o_x),
    .o_y_out       (o_y),
    .o_colour_out  (o_col),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  // Accepted-pixel monitor, sampled on the falling edge
  logic       mon_clr = 1'b1;
  int         m_cnt, m_done, m_sx, m_sy, m_c0, m_cx, m_co;
  logic [7:0] m_fx, m_lx, m_minx, m_maxx;
  logic [6:0] m_fy, m_ly, m_miny, m_maxy;
  logic [2:0] m_cor, m_cand;

  always @(negedge clk) begin
    if (mon_clr) begin
      m_cnt <= 0;  m_done <= 0; m_sx <= 0; m_sy <= 0;
      m_c0 <= 0;   m_cx <= 0;   m_co <= 0;
      m_fx <= '0;  m_fy <= '0;  m_lx <= '0; m_ly <= '0;
      m_minx <= '1; m_maxx <= '0; m_miny <= '1; m_maxy <= '0;
      m_cor <= '0; m_cand <= '1;
    end else begin
      if (o_done) m_done <= m_done + 1;
      if (o_plot && plot_ready) begin
        if (m_cnt == 0) begin
          m_fx <= o_x;
          m_fy <= o_y;
        end
        m_cnt <= m_cnt + 1;
        m_lx  <= o_x;
        m_ly  <= o_y;
        m_sx  <= m_sx + int'(o_x);
        m_sy  <= m_sy + int'(o_y);
        if (o_x < m_minx) m_minx <= o_x;
        if (o_x > m_maxx) m_maxx <= o_x;
        if (o_y < m_miny) m_miny <= o_y;
        if (o_y > m_maxy) m_maxy <= o_y;
        m_cor  <= m_cor | o_col;
        m_cand <= m_cand & o_col;
        case (o_col)
          3'b000:  m_c0 <= m_c0 + 1;
          3'b100:  m_cx <= m_cx + 1;
          3'b001:  m_co <= m_co + 1;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_reset();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
    step();
  endtask

  task automatic pulse_start(input logic full);
    full_redraw = full;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 20000) begin
      step();
      n++;
    end
    chk(tag, {31'd0, o_done}, 32'd1);
    repeat (3) step();
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    start       = 1'b0;
    full_redraw = 1'b0;
    cell_state  = 18'h00000;
    plot_ready  = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_plot", {31'd0, o_plot}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_xyc",  {14'd0, o_x, o_y, o_col}, 32'd0);

    // Pass 1: empty board, dirty mode, everything drawn after reset
    mon_reset();
    pulse_start(1'b0);
    chk("lat1_busy", {31'd0, o_busy}, 32'd1);
    chk("lat1_plot", {31'd0, o_plot}, 32'd0);
    step();
    chk("lat2_pix", {16'd0, o_plot, o_x, o_y}, {16'd0, 1'b1, 8'd0, 7'd0});

    // Stall at cell 4, cx = 3
    n = 0;
    while (!(o_plot && o_x == 8'd30 && o_y == 7'd27) && n < 5000) begin
      step();
      n++;
    end
    chk("stall_reach", {31'd0, (o_plot && o_x == 8'd30 && o_y == 7'd27)}, 32'd1);
    plot_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold", {16'd0, o_plot, o_x, o_y}, {16'd0, 1'b1, 8'd30, 7'd27});
    end
    plot_ready = 1'b1;
    wait_done("p1_done");
    chk("p1_cnt",   m_cnt, 32'd6084);
    chk("p1_first", {17'd0, m_fx, m_fy}, {17'd0, 8'd0, 7'd0});
    chk("p1_last",  {17'd0, m_lx, m_ly}, {17'd0, 8'd79, 7'd79});
    chk("p1_sumx",  m_sx, 32'd240318);
    chk("p1_sumy",  m_sy, 32'd240318);
    chk("p1_col",   {29'd0, m_cor}, 32'd0);
    chk("p1_ndone", m_done, 32'd1);
    chk("p1_busy",  {31'd0, o_busy}, 32'd0);

    // Pass 3: cell 5 becomes X
    mon_reset();
    cell_state = 18'h00400;
    pulse_start(1'b0);
    wait_done("p3_done");
    chk("p3_cnt",  m_cnt, 32'd676);
    chk("p3_xrng", {16'd0, m_minx, m_maxx}, {16'd0, 8'd54, 8'd79});
    chk("p3_yrng", {18'd0, m_miny, m_maxy}, {18'd0, 7'd27, 7'd52});
    chk("p3_col",  {26'd0, m_cor, m_cand}, {26'd0, 3'b100, 3'b100});

    // Pass 4: nothing changed, done 11 cycles after start
    mon_reset();
    full_redraw = 1'b0;
    start       = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      start = 1'b0;
      chk("p4_done_t", {31'd0, o_done}, {31'd0, (i == 11)});
    end
    repeat (2) step();
    chk("p4_cnt", m_cnt, 32'd0);

    // Pass 5: reset in the middle of drawing cell 0
    cell_state = 18'h00002;
    pulse_start(1'b0);
    n = 0;
    while (!o_plot && n < 100) begin
      step();
      n++;
    end
    chk("p5_plotting", {31'd0, o_plot}, 32'd1);
    repeat (10) step();
    reset = 1'b1;
    #1;
    chk("p5_rst_plot", {31'd0, o_plot}, 32'd0);
    chk("p5_rst_busy", {31'd0, o_busy}, 32'd0);
    step();
    reset = 1'b0;
    mon_reset();
    pulse_start(1'b0);
    wait_done("p5_done");
    chk("p5_cnt", m_cnt, 32'd6084);

    // Pass 6: full redraw of S1; start and board change while busy are ignored
    mon_reset();
    cell_state = 18'h00231;
    pulse_start(1'b1);
    repeat (100) step();
    cell_state  = 18'h10232;
    full_redraw = 1'b0;
    start       = 1'b1;
    step();
    start = 1'b0;
    wait_done("p6_done");
    repeat (20) step();
    chk("p6_cnt",   m_cnt, 32'd6084);
    chk("p6_x",     m_cx, 32'd676);
    chk("p6_o",     m_co, 32'd676);
    chk("p6_empty", m_c0, 32'd4732);
    chk("p6_ndone", m_done, 32'd1);
    chk("p6_busy",  {31'd0, o_busy}, 32'd0);

    // Dirty pass redraws the cells changed mid-pass (cells 0 and 8)
    mon_reset();
    pulse_start(1'b0);
    wait_done("p7_done");
    chk("p7_cnt", m_cnt, 32'd1352);
    chk("p7_o",   m_co, 32'd676);
    chk("p7_x",   m_cx, 32'd676);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
